// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch display path.
package stopwatch_pkg;

   typedef logic [3:0] bcd_t;
   typedef logic [6:0] seg_t;

   // Segment order {g,f,e,d,c,b,a}, active-low.
   localparam seg_t SEG_BLANK = 7'h7F;
   localparam seg_t SEG_DASH  = 7'b0111111;

   localparam logic [1:0] IDX_TENTHS  = 2'd0;
   localparam logic [1:0] IDX_SECONDS = 2'd1;
   localparam logic [1:0] IDX_MINUTES = 2'd2;

   typedef enum logic {
      PHASE_VISIBLE = 1'b0,
      PHASE_BLANK   = 1'b1
   } blink_phase_t;

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes show a dash.
module bcd_to_seg
   import stopwatch_pkg::*;
(
   input  bcd_t bcd,
   output seg_t seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0: seg = 7'b1000000;
         4'd1: seg = 7'b1111001;
         4'd2: seg = 7'b0100100;
         4'd3: seg = 7'b0110000;
         4'd4: seg = 7'b0011001;
         4'd5: seg = 7'b0010010;
         4'd6: seg = 7'b0000010;
         4'd7: seg = 7'b1111000;
         4'd8: seg = 7'b0000000;
         4'd9: seg = 7'b0010000;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Three-digit multiplexed display driver with frame-coherent snapshot and flash blinking.
// Define LEADING_ZERO_BLANK_EN to blank a zero minutes digit (anode timing unchanged).
module seg_scan_driver
   import stopwatch_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 12500000
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] minutes_bcd,
   input  logic [3:0] seconds_bcd,
   input  logic [3:0] tenths_bcd,
   input  logic       digits_valid,
   input  logic       flash,
   output logic [6:0] seg_n,
   output logic       dp_n,
   output logic [2:0] an_n,
   output logic       frame_tick
);

   localparam int RW = $clog2(REFRESH_DIV);
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [RW-1:0] REFRESH_PRE  = RW'(REFRESH_DIV - 2);
   localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

   logic [RW-1:0] refresh_cnt_reg, refresh_cnt_next;
   logic [1:0]    scan_idx_reg, scan_idx_next;
   logic          refresh_last, frame_wrap, frame_pre;
   logic          pending_reg;

   logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
   blink_phase_t  blink_phase_reg, blink_phase_next;
   logic          blink_last, display_blank;

   bcd_t          digit_in [3];
   bcd_t          active_digit [3];
   bcd_t          cur_digit;
   seg_t          dec_seg, seg_sel;
   logic [2:0]    an_sel;

   logic [6:0]    seg_n_reg;
   logic          dp_n_reg;
   logic [2:0]    an_n_reg;
   logic          frame_tick_reg;

   assign digit_in[IDX_TENTHS]  = tenths_bcd;
   assign digit_in[IDX_SECONDS] = seconds_bcd;
   assign digit_in[IDX_MINUTES] = minutes_bcd;

   // Scan timing
   assign refresh_last = (refresh_cnt_reg == REFRESH_LAST);
   assign frame_wrap   = refresh_last && (scan_idx_reg == IDX_MINUTES);
   // One cycle early so the registered tick lands on the wrap cycle itself.
   assign frame_pre    = (refresh_cnt_reg == REFRESH_PRE) && (scan_idx_reg == IDX_MINUTES);

   always_comb begin
      refresh_cnt_next = refresh_cnt_reg + RW'(1);
      scan_idx_next    = scan_idx_reg;
      if (refresh_last) begin
         refresh_cnt_next = '0;
         scan_idx_next    = frame_wrap ? IDX_TENTHS : scan_idx_reg + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         refresh_cnt_reg <= '0;
         scan_idx_reg    <= IDX_TENTHS;
         pending_reg     <= 1'b0;
      end else begin
         refresh_cnt_reg <= refresh_cnt_next;
         scan_idx_reg    <= scan_idx_next;
         if (frame_wrap)
            pending_reg <= 1'b0;
         else if (digits_valid)
            pending_reg <= 1'b1;
      end
   end

   // Per-digit shadow/active pair; a strobe on the wrap cycle bypasses the shadow.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_digit
         bcd_t shadow_reg;
         bcd_t active_reg;

         always_ff @(posedge clk) begin
            if (!reset) begin
               shadow_reg <= '0;
               active_reg <= '0;
            end else begin
               if (digits_valid)
                  shadow_reg <= digit_in[gi];
               if (frame_wrap) begin
                  if (digits_valid)
                     active_reg <= digit_in[gi];
                  else if (pending_reg)
                     active_reg <= shadow_reg;
               end
            end
         end

         assign active_digit[gi] = active_reg;
      end
   endgenerate

   // Blink FSM: state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         blink_phase_reg <= PHASE_VISIBLE;
         blink_cnt_reg   <= '0;
      end else begin
         blink_phase_reg <= blink_phase_next;
         blink_cnt_reg   <= blink_cnt_next;
      end
   end

   // Blink FSM: next state
   assign blink_last = (blink_cnt_reg == BLINK_LAST);

   always_comb begin
      blink_phase_next = blink_phase_reg;
      blink_cnt_next   = blink_cnt_reg + BW'(1);
      if (!flash) begin
         blink_phase_next = PHASE_VISIBLE;
         blink_cnt_next   = '0;
      end else if (blink_last) begin
         blink_phase_next = (blink_phase_reg == PHASE_VISIBLE) ? PHASE_BLANK : PHASE_VISIBLE;
         blink_cnt_next   = '0;
      end
   end

   // Blink FSM: output; uses the next phase so dropping flash unblanks on the next edge.
   always_comb begin
      display_blank = (blink_phase_next == PHASE_BLANK);
   end

   // Digit mux and decode
   always_comb begin
      cur_digit = active_digit[IDX_TENTHS];
      an_sel    = 3'b110;
      case (scan_idx_reg)
         IDX_SECONDS: begin
            cur_digit = active_digit[IDX_SECONDS];
            an_sel    = 3'b101;
         end
         IDX_MINUTES: begin
            cur_digit = active_digit[IDX_MINUTES];
            an_sel    = 3'b011;
         end
         default: begin
            cur_digit = active_digit[IDX_TENTHS];
            an_sel    = 3'b110;
         end
      endcase
   end

   bcd_to_seg u_bcd_to_seg (
      .bcd (cur_digit),
      .seg (dec_seg)
   );

`ifdef LEADING_ZERO_BLANK_EN
   assign seg_sel = ((scan_idx_reg == IDX_MINUTES) && (cur_digit == 4'd0)) ? SEG_BLANK : dec_seg;
`else
   assign seg_sel = dec_seg;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         seg_n_reg      <= SEG_BLANK;
         dp_n_reg       <= 1'b1;
         an_n_reg       <= 3'b111;
         frame_tick_reg <= 1'b0;
      end else begin
         frame_tick_reg <= frame_pre;
         if (display_blank) begin
            seg_n_reg <= SEG_BLANK;
            dp_n_reg  <= 1'b1;
            an_n_reg  <= 3'b111;
         end else begin
            seg_n_reg <= seg_sel;
            dp_n_reg  <= (scan_idx_reg != IDX_SECONDS);
            an_n_reg  <= an_sel;
         end
      end
   end

   assign seg_n      = seg_n_reg;
   assign dp_n       = dp_n_reg;
   assign an_n       = an_n_reg;
   assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: expected digit slots queued per frame, checked as slots appear.
module tb_seg_scan_driver;

   localparam int REFRESH_DIV = 4;
   localparam int BLINK_DIV   = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] minutes_bcd = '0;
   logic [3:0] seconds_bcd = '0;
   logic [3:0] tenths_bcd = '0;
   logic       digits_valid = 1'b0;
   logic       flash = 1'b0;
   logic [6:0] seg_n;
   logic       dp_n;
   logic [2:0] an_n;
   logic       frame_tick;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [2:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   exp_t sb_q[$];

   seg_scan_driver #(
      .REFRESH_DIV (REFRESH_DIV),
      .BLINK_DIV   (BLINK_DIV)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .minutes_bcd  (minutes_bcd),
      .seconds_bcd  (seconds_bcd),
      .tenths_bcd   (tenths_bcd),
      .digits_valid (digits_valid),
      .flash        (flash),
      .seg_n        (seg_n),
      .dp_n         (dp_n),
      .an_n         (an_n),
      .frame_tick   (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: seg_of = 7'b1000000;
         4'd1: seg_of = 7'b1111001;
         4'd2: seg_of = 7'b0100100;
         4'd3: seg_of = 7'b0110000;
         4'd4: seg_of = 7'b0011001;
         4'd5: seg_of = 7'b0010010;
         4'd6: seg_of = 7'b0000010;
         4'd7: seg_of = 7'b1111000;
         4'd8: seg_of = 7'b0000000;
         4'd9: seg_of = 7'b0010000;
         default: seg_of = 7'b0111111;
      endcase
   endfunction

   task automatic push_frame(input logic [3:0] m, input logic [3:0] s, input logic [3:0] t);
      logic [6:0] mseg;
      mseg = seg_of(m);
`ifdef LEADING_ZERO_BLANK_EN
      if (m == 4'd0) mseg = 7'h7F;
`endif
      sb_q.push_back('{an: 3'b110, seg: seg_of(t), dp: 1'b1});
      sb_q.push_back('{an: 3'b101, seg: seg_of(s), dp: 1'b0});
      sb_q.push_back('{an: 3'b011, seg: mseg,      dp: 1'b1});
   endtask

   // Called at a negedge; holds the strobe for exactly one rising edge.
   task automatic strobe(input logic [3:0] m, input logic [3:0] s, input logic [3:0] t);
      minutes_bcd  = m;
      seconds_bcd  = s;
      tenths_bcd   = t;
      digits_valid = 1'b1;
      @(negedge clk);
      digits_valid = 1'b0;
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 100);
      if (!frame_tick) check_val("tick_timeout", 16'(frame_tick), 16'd1);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) check_val("drain_timeout", 16'(sb_q.size()), 16'd0);
   endtask

   // Monitor: each new visible digit slot is compared against the next queued entry.
   initial begin
      logic [2:0] prev_an;
      exp_t e;
      prev_an = 3'b111;
      forever begin
         @(negedge clk);
         if (an_n != prev_an && an_n != 3'b111 && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("slot_an",  16'(an_n),  16'(e.an));
            check_val("slot_seg", 16'(seg_n), 16'(e.seg));
            check_val("slot_dp",  16'(dp_n),  16'(e.dp));
         end
         prev_an = an_n;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;

      // Reset held for three edges
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_seg",   16'(seg_n),      16'h7F);
      check_val("rst_an",    16'(an_n),       16'b111);
      check_val("rst_dp",    16'(dp_n),       16'd1);
      check_val("rst_tick",  16'(frame_tick), 16'd0);
      reset = 1'b1;
      @(negedge clk);
      check_val("rel_an",  16'(an_n),  16'b110);
      check_val("rel_seg", 16'(seg_n), 16'h40);

      // Scan 3/5/7 and frame period
      strobe(4'd3, 4'd5, 4'd7);
      wait_tick(n);
      push_frame(4'd3, 4'd5, 4'd7);
      wait_tick(n);
      check_val("tick_period", 16'(n), 16'd12);
      wait_drain();

      // Coherence: two strobes mid-frame, only the latest appears next frame
      wait_tick(n);
      push_frame(4'd3, 4'd5, 4'd7);
      repeat (3) @(negedge clk);
      strobe(4'd1, 4'd2, 4'd3);
      @(negedge clk);
      strobe(4'd4, 4'd5, 4'd6);
      wait_tick(n);
      push_frame(4'd4, 4'd5, 4'd6);
      wait_drain();

      // Strobe on the wrap cycle goes straight into the new frame
      wait_tick(n);
      minutes_bcd  = 4'd9;
      seconds_bcd  = 4'd9;
      tenths_bcd   = 4'd9;
      digits_valid = 1'b1;
      push_frame(4'd9, 4'd9, 4'd9);
      @(negedge clk);
      digits_valid = 1'b0;
      wait_drain();

      // Invalid tenths code and zero minutes
      strobe(4'd0, 4'd0, 4'hC);
      wait_tick(n);
      push_frame(4'd0, 4'd0, 4'hC);
      wait_drain();

      // Blink
      flash = 1'b1;
      n = 0;
      while (an_n != 3'b111 && n < 64) begin
         @(negedge clk);
         n++;
      end
      check_val("blank_seen", 16'(an_n), 16'b111);
      check_val("blank_seg",  16'(seg_n), 16'h7F);
      check_val("blank_dp",   16'(dp_n),  16'd1);
      n = 0;
      while (an_n == 3'b111 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_val("blank_len", 16'(n), 16'd16);
      n = 0;
      while (an_n != 3'b111 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_val("visible_len", 16'(n), 16'd16);
      repeat (5) @(negedge clk);
      check_val("still_blank", 16'(an_n), 16'b111);
      flash = 1'b0;
      @(negedge clk);
      check_val("unblank_onehot", 16'($countones(~an_n)), 16'd1);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
